tinyalu_responder: RTL

- Synthesizable TinyALU responder: the DUT side of the start/done protocol that the TinyALU bench BFM drives.
- Accepts an 8-bit operand pair and a 3-bit opcode when `start` is asserted.
- Executes add/and/xor in one cycle and multiply in `MUL_LATENCY` cycles.
- Returns a 16-bit `result` qualified by a one-cycle `done` pulse. Sits directly under the bench top in place of the TinyALU core.

---
 rtl/tinyalu_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/tinyalu_responder.sv
// TinyALU responder: accepts a start/op/A/B command and answers with a
// registered result plus a one-cycle done pulse; multiply takes MUL_LATENCY cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; no_op ignored, rst_op clears result
// ALU      | operands captured; add/and/xor/unused complete on next edge
// MUL      | operands captured; counting down to multiply completion
// WAIT_LOW | done pulsed; waiting for start to drop before re-arming
module tinyalu_responder #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {IDLE, ALU, MUL, WAIT_LOW} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  op_q;
  logic [3:0]  cnt;
  logic [15:0] alu_res;
  logic [15:0] product;
  logic [8:0]  sum;

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign product = 16'(a_q) * 16'(b_q);

  // Unused opcodes fall through to zero so the initiator still sees done.
  always_comb begin
    alu_res = 16'h0000;
    case (op_q)
      OP_ADD:  alu_res = {7'b0, sum};
      OP_AND:  alu_res = {8'h00, a_q & b_q};
      OP_XOR:  alu_res = {8'h00, a_q ^ b_q};
      default: alu_res = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 16'h0000;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      op_q   <= 3'b000;
      cnt    <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_NOP: ;
              OP_RST: result <= 16'h0000;
              OP_MUL: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                cnt   <= MUL_LOAD;
                state <= MUL;
              end
              default: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                state <= ALU;
              end
            endcase
          end
        end
        ALU: begin
          result <= alu_res;
          done   <= 1'b1;
          state  <= WAIT_LOW;
        end
        MUL: begin
          if (cnt == 4'h0) begin
            result <= product;
            done   <= 1'b1;
            state  <= WAIT_LOW;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        WAIT_LOW: begin
          // A held start must not be re-accepted as a new command.
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
